card_deck_shuffler: RTL and testbench
=====================================

# card_deck_shuffler

Builds the shuffled card layout for a new game from the card count selected on the options screen. On `start` it latches `num_of_cards`, fills an internal deck with matched pairs of card IDs, then permutes it with a Fisher-Yates shuffle driven by a free-running LFSR. It sits directly downstream of the difficulty selection and feeds the board renderer and the match checker through a registered read port.

## Interface
- `MAX_CARDS`, 24: deck capacity. Must be even and ≤ 2^`NUM_W`−1.
- `NUM_W`, 6: width of `num_of_cards`, `rd_addr` and `deck_size`.
- `ID_W`, 5: card ID width. Must satisfy `NUM_W`−1 ≤ `ID_W`.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to build a new deck. Ignored while `busy`=1.
- `num_of_cards`  in  `NUM_W`  requested card count. Sampled only in the cycle `start` is accepted.
- `rd_addr`  in  `NUM_W`  board position to read.
- `rd_data`  out  `ID_W`  card ID at `rd_addr`, registered.
- `deck_size`  out  `NUM_W`  effective card count of the last deck built.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  single-cycle pulse when the deck is ready.

## Operation
- Effective count: N = min(`num_of_cards` with bit 0 cleared, `MAX_CARDS`). It is latched into `deck_size` when `start` is accepted.
- FSM states: IDLE, FILL, PICK, SWAP, DONE.
  - IDLE: when `start`=1, latch N, set k=0, set `busy`=1, go to FILL. If N=0, go directly to DONE and leave the deck unchanged.
  - FILL: write deck[k] = k>>1, one entry per cycle. After k=N−1, set i=N−1 and go to PICK.
  - PICK: r = lfsr[`NUM_W`−1:0] & mask(i), where mask(i) is the OR-smear of i (smallest 2^m−1 ≥ i).
    - If r ≤ i: set j=r and go to SWAP.
    - Otherwise stay in PICK and retry next cycle with the new LFSR value. The acceptance rate is ≥ 50%.
  - SWAP: exchange deck[i] and deck[j] in one cycle (j=i is a legal no-op). If i=1, go to DONE. Otherwise i←i−1 and go to PICK.
  - DONE: `done`=1 for one cycle, `busy`←0, return to IDLE.
- LFSR: 16-bit Galois, feedback mask 16'hB400, shifts right every cycle in all states. A `start` at a different cycle therefore yields a different shuffle.
- Deck storage: register array of `MAX_CARDS` entries. Entries at index ≥ N keep their old values.
- Read port: `rd_data` ← deck[`rd_addr`] on every clock. If `rd_addr` ≥ `MAX_CARDS`, `rd_data` ← 0. Reads during `busy` return current, partially built contents; consumers must wait for `done`.
- `rst` in any state:
  - state←IDLE, LFSR←`LFSR_SEED`.
  - All deck entries, `rd_data`, `deck_size`, `busy` and `done` ←0.
  - Any operation in progress is abandoned and no `done` is issued.

## Timing
- `start` at cycle T → `busy`=1 at T+1.
- FILL takes N cycles. SWAP takes N−1 cycles. PICK takes ≥ 1 cycle per swap.
- Minimum latency from `start` to `done` is 3N cycles.
- With N=0, `done` is asserted at T+2.
- `rd_data` latency is 1 cycle from `rd_addr`.
- `done` and `busy`=0 take effect in the same cycle. A `start` in that cycle is accepted.

## Configuration
- `DECK_SHUFFLE_EN` defined: full behaviour as above.
- `DECK_SHUFFLE_EN` undefined:
  - PICK and SWAP are not compiled; FILL goes directly to DONE.
  - The deck stays in sorted pair order 0,0,1,1,… for debug and deterministic board tests.
  - Latency from `start` to `done` is N+2 cycles. The LFSR may be removed.

## Test plan
- Reset, then read addresses 0..23 → `rd_data`=0, `deck_size`=0, `busy`=0, `done`=0.
- Macro undefined, `start` with `num_of_cards`=16:
  - `done` arrives 18 cycles after `start`.
  - Deck reads 0,0,1,1,…,7,7; addresses 16..23 read 0.
- Macro defined, `start` with N=24 issued 10 cycles after reset:
  - The deck matches the golden model (same LFSR and seed).
  - Each ID 0..11 appears exactly twice.
- `num_of_cards`=31 → `deck_size`=24. `num_of_cards`=7 → `deck_size`=6. `num_of_cards`=1 → `deck_size`=0, and `done` arrives 2 cycles after `start`.
- `start` pulsed while `busy` → no restart, and exactly one `done`.
- `rst` asserted in the middle of PICK:
  - The next cycle shows IDLE, `busy`=0 and an all-zero deck, with no `done`.
  - A following `start` completes normally.

Source files
------------

// File: rtl/card_deck_shuffler.sv
// card_deck_shuffler: fills a deck with matched card-ID pairs and optionally
// permutes it with a Fisher-Yates shuffle driven by a free-running LFSR.
// Build option: define DECK_SHUFFLE_EN to compile the PICK/SWAP shuffle
// stages; when undefined the deck is left in sorted pair order.
module card_deck_shuffler #(
  parameter int unsigned MAX_CARDS = 24,
  parameter int unsigned NUM_W     = 6,
  parameter int unsigned ID_W      = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num_of_cards,
  input  logic [NUM_W-1:0] rd_addr,
  output logic [ID_W-1:0]  rd_data,
  output logic [NUM_W-1:0] deck_size,
  output logic             busy,
  output logic             done
);

`ifdef DECK_SHUFFLE_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PICK, S_SWAP, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [NUM_W-1:0]  k_q, k_d;
  logic [NUM_W-1:0]  n_q, n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   rd_q, rd_d;
  logic [ID_W-1:0]   deck_q [MAX_CARDS];
  logic [ID_W-1:0]   deck_d [MAX_CARDS];
  logic [NUM_W-1:0]  n_even, n_req;
`ifdef DECK_SHUFFLE_EN
  logic [NUM_W-1:0]  i_q, i_d;
  logic [NUM_W-1:0]  j_q, j_d;
  logic [NUM_W-1:0]  mask_c, r_c;
  logic [ID_W-1:0]   di_c, dj_c;
`endif

  assign rd_data   = rd_q;
  assign deck_size = n_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Effective card count: round down to even, clamp to deck capacity.
  always_comb begin
    n_even = num_of_cards & ~NUM_W'(1);
    n_req  = (n_even > NUM_W'(MAX_CARDS)) ? NUM_W'(MAX_CARDS) : n_even;
  end

  // Galois LFSR, right shift, runs every cycle regardless of state.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Next-state logic, deck updates and registered read port mux.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    deck_d  = deck_q;
    rd_d    = '0;
`ifdef DECK_SHUFFLE_EN
    i_d     = i_q;
    j_d     = j_q;
    // OR-smear of i gives the smallest 2^m-1 >= i, so r <= i at least half the time.
    mask_c  = i_q;
    for (int unsigned s = 1; s < NUM_W; s++) begin
      mask_c = mask_c | (mask_c >> 1);
    end
    r_c     = lfsr_q[NUM_W-1:0] & mask_c;
    di_c    = '0;
    dj_c    = '0;
    for (int unsigned a = 0; a < MAX_CARDS; a++) begin
      if (NUM_W'(a) == i_q) di_c = deck_q[a];
      if (NUM_W'(a) == j_q) dj_c = deck_q[a];
    end
`endif

    for (int unsigned a = 0; a < MAX_CARDS; a++) begin
      if (NUM_W'(a) == rd_addr) rd_d = deck_q[a];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n_req;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = (n_req == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        for (int unsigned a = 0; a < MAX_CARDS; a++) begin
          if (NUM_W'(a) == k_q) deck_d[a] = ID_W'(k_q >> 1);
        end
        if (k_q == n_q - NUM_W'(1)) begin
`ifdef DECK_SHUFFLE_EN
          i_d     = n_q - NUM_W'(1);
          state_d = S_PICK;
`else
          state_d = S_DONE;
`endif
        end else begin
          k_d = k_q + NUM_W'(1);
        end
      end
`ifdef DECK_SHUFFLE_EN
      S_PICK: begin
        if (r_c <= i_q) begin
          j_d     = r_c;
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        for (int unsigned a = 0; a < MAX_CARDS; a++) begin
          if (NUM_W'(a) == j_q) deck_d[a] = di_c;
          if (NUM_W'(a) == i_q) deck_d[a] = dj_c;
        end
        if (i_q == NUM_W'(1)) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q - NUM_W'(1);
          state_d = S_PICK;
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, LFSR, deck and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      k_q     <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      for (int unsigned a = 0; a < MAX_CARDS; a++) begin
        deck_q[a] <= '0;
      end
`ifdef DECK_SHUFFLE_EN
      i_q     <= '0;
      j_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      k_q     <= k_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      deck_q  <= deck_d;
`ifdef DECK_SHUFFLE_EN
      i_q     <= i_d;
      j_q     <= j_d;
`endif
    end
  end

endmodule

// File: tb/tb_card_deck_shuffler.sv
// Directed bench for card_deck_shuffler; expected decks and latencies come
// from a small behavioural model (sorted pairs, plus Fisher-Yates when
// DECK_SHUFFLE_EN is defined).
module tb_card_deck_shuffler;
  localparam int MAXC = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] num_of_cards = '0;
  logic [5:0] rd_addr = '0;
  logic [4:0] rd_data;
  logic [5:0] deck_size;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_lfsr;
  int exp_deck [MAXC];
  int exp_lat;
  int exp_n;

  card_deck_shuffler #(
    .MAX_CARDS(24),
    .NUM_W(6),
    .ID_W(5),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_of_cards(num_of_cards),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .deck_size(deck_size),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR tracking the value held in each cycle.
  always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lfsr_step(m_lfsr);

  function automatic int smallest_mask(int i);
    int m = 0;
    while (m < i) m = m * 2 + 1;
    return m;
  endfunction

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compute expected deck, size and start-to-done latency; l0 is the LFSR
  // value present in the cycle start is accepted.
  task automatic model(int nreq, logic [15:0] l0);
    int n;
    int lat;
    logic [15:0] l;
    n = nreq & ~1;
    if (n > MAXC) n = MAXC;
    exp_n = n;
    if (n == 0) begin
      exp_lat = 2;
      return;
    end
    for (int k = 0; k < n; k++) exp_deck[k] = k / 2;
    lat = n + 2;
    l = l0;
`ifdef DECK_SHUFFLE_EN
    repeat (n + 1) l = lfsr_step(l);
    for (int i = n - 1; i >= 1; i--) begin
      int r;
      int t;
      do begin
        r = int'(l[5:0]) & smallest_mask(i);
        l = lfsr_step(l);
        lat++;
      end while (r > i);
      t = exp_deck[i];
      exp_deck[i] = exp_deck[r];
      exp_deck[r] = t;
      l = lfsr_step(l);
      lat++;
    end
`endif
    exp_lat = lat;
  endtask

  task automatic clear_model();
    for (int a = 0; a < MAXC; a++) exp_deck[a] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  // Read the whole deck plus two out-of-range addresses; optionally count pairs.
  task automatic check_deck(string tag, bit pairs);
    int got [MAXC];
    for (int a = 0; a < MAXC; a++) begin
      rd_addr = 6'(a);
      @(posedge clk); #1;
      got[a] = int'(rd_data);
      check($sformatf("%s rd[%0d]", tag, a), got[a], exp_deck[a]);
    end
    rd_addr = 6'd24;
    @(posedge clk); #1;
    check({tag, " rd[24]"}, int'(rd_data), 0);
    rd_addr = 6'd63;
    @(posedge clk); #1;
    check({tag, " rd[63]"}, int'(rd_data), 0);
    if (pairs) begin
      for (int id = 0; id < exp_n / 2; id++) begin
        int c = 0;
        for (int a = 0; a < exp_n; a++) if (got[a] == id) c++;
        check($sformatf("%s pair id%0d", tag, id), c, 2);
      end
    end
  endtask

  // Issue a start (called #1 after a clock edge) and time the done pulse.
  task automatic run_start(int nreq, string tag);
    int cnt;
    start = 1'b1;
    num_of_cards = 6'(nreq);
    model(nreq, m_lfsr);
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 1;
    check({tag, " busy@T+1"}, int'(busy), 1);
    while (!done && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, " latency"}, cnt, exp_lat);
    check({tag, " busy@done"}, int'(busy), 0);
    check({tag, " deck_size"}, int'(deck_size), exp_n);
    @(posedge clk); #1;
    check({tag, " done 1-cycle"}, int'(done), 0);
  endtask

  initial begin
    int ndone;
    int cnt;

    // Reset state
    do_reset();
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst deck_size", int'(deck_size), 0);
    check_deck("rst", 1'b0);

    // First build 10 cycles after reset
    do_reset();
    repeat (9) @(posedge clk);
    #1;
`ifdef DECK_SHUFFLE_EN
    run_start(24, "n24");
    check_deck("n24", 1'b1);
`else
    run_start(16, "n16");
    check_deck("n16", 1'b1);
`endif

    // Count clamping and rounding
    run_start(31, "n31");
    check_deck("n31", 1'b0);
    run_start(7, "n7");
    check_deck("n7", 1'b0);
    run_start(1, "n1");
    check_deck("n1", 1'b0);

    // Start while busy is ignored
    start = 1'b1;
    num_of_cards = 6'd16;
    model(16, m_lfsr);
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 1;
    ndone = 0;
    while (cnt < exp_lat + 10) begin
      if (cnt == 4) begin
        start = 1'b1;
        num_of_cards = 6'd4;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
      if (done) ndone++;
    end
    start = 1'b0;
    check("busy-restart done count", ndone, 1);
    check("busy-restart deck_size", int'(deck_size), 16);
    check_deck("busy-restart", 1'b0);

    // Reset in the middle of an operation
    start = 1'b1;
    num_of_cards = 6'd16;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef DECK_SHUFFLE_EN
    repeat (20) @(posedge clk);
`else
    repeat (8) @(posedge clk);
`endif
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst deck_size", int'(deck_size), 0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst no done", ndone, 0);
    check_deck("midrst", 1'b0);
    run_start(8, "after-rst n8");
    check_deck("after-rst n8", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
